dmem_arb: RTL and testbench
===========================

DMEM_ARB -- requirements
Module: dmem_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, width of address buses.
REQ-002 SHALL have parameter DATA_W, default 32, width of data buses.
REQ-003 SHALL have parameter MAX_HOLD, default 4, maximum consecutive grants to one locked master (legal range 1..15).
REQ-004 SHALL have one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 m0_req / m1_req  input  1  master n requests one access this cycle.
REQ-008 m0_we / m1_we  input  1  1 = write, 0 = read.
REQ-009 m0_addr / m1_addr  input  ADDR_W  word address.
REQ-010 m0_wdata / m1_wdata  input  DATA_W  write data.
REQ-011 m0_lock / m1_lock  input  1  request to keep ownership for following accesses.
REQ-012 m0_gnt / m1_gnt  output  1  combinational grant; req & gnt = access performed this cycle.
REQ-013 m0_rvalid / m1_rvalid  output  1  one-cycle pulse, read data valid.
REQ-014 m0_rdata / m1_rdata  output  DATA_W  registered read data, shared register, qualified by rvalid.
REQ-015 mem_addr  output  ADDR_W  address to data memory.
REQ-016 mem_wdata  output  DATA_W  write data to data memory.
REQ-017 mem_rw  output  1  memory control, 0 = write, 1 = read.
REQ-018 mem_rdata  input  DATA_W  combinational read data from memory.

Function
REQ-019 SHALL assert at most one gnt per cycle; gnt only to a master with req high.
REQ-020 State: last (1 bit, last granted master), owner_valid (1 bit), hold_cnt (4 bits), rd_pend (1 bit), rd_id (1 bit), rdata_q (DATA_W).
REQ-021 Lock rule: if owner_valid, owner req=1, owner lock=1 and hold_cnt < MAX_HOLD-1, owner SHALL be granted regardless of other req.
REQ-022 Otherwise round-robin: if both req, grant master != last; if one req, grant it; if none, no grant.
REQ-023 On grant to the same master as last with owner_valid=1: hold_cnt <= hold_cnt+1 (saturating at 15); on grant to the other master or with owner_valid=0: hold_cnt <= 0.
REQ-024 On grant: last <= granted id, owner_valid <= 1; on idle cycle (no grant): owner_valid <= 0, hold_cnt <= 0, last unchanged.
REQ-025 When MAX_HOLD reached and other master requests, other master SHALL be granted next; if other master idle, lock holder continues (hold_cnt saturates, round-robin selects it).
REQ-026 Muxing: mem_addr/mem_wdata = granted master fields; mem_rw = ~granted we; no grant -> mem_rw=1, mem_addr=0, mem_wdata=0.
REQ-027 Write SHALL complete in the grant cycle (memory samples on that clock edge); no response pulse for writes.
REQ-028 Read: rdata_q <= mem_rdata at end of grant cycle; rvalid of the granting master SHALL pulse exactly 1 cycle later (latency 1); back-to-back reads give back-to-back pulses.
REQ-029 m0_rdata and m1_rdata SHALL both equal rdata_q; rdata_q holds value when no read granted.
REQ-030 A master SHALL NOT be granted while its req is low, even if locked owner.

Reset
REQ-031 On rst=1 at clock edge: last <= 1 (m0 wins first contention), owner_valid <= 0, hold_cnt <= 0, rd_pend <= 0, rdata_q <= 0.
REQ-032 During rst=1 all gnt SHALL be 0, all rvalid 0, mem_rw=1, mem_addr=0, mem_wdata=0.
REQ-033 Reset asserted the cycle after a read grant SHALL suppress that rvalid pulse.

Verification
REQ-034 Post-reset both req, no lock, reads to 0x10 (m0) and 0x20 (m1) -> grants m0,m1,m0,m1 alternating; each rvalid one cycle after its grant with mem content of its address.
REQ-035 m1 write addr 0x8 data 0xDEADBEEF then m0 read 0x8 -> cycle1 m1_gnt, mem_rw=0; cycle2 m0_gnt; cycle3 m0_rvalid=1, m0_rdata=0xDEADBEEF, m1_rvalid=0.
REQ-036 MAX_HOLD=4, m0 req+lock continuous, m1 req continuous -> m0 granted 4 consecutive cycles, then m1 granted 5th cycle.
REQ-037 m1 alone with lock for 10 cycles -> m1_gnt every cycle, hold_cnt saturates, no idle gaps; m0 raises req at cycle 11 -> granted within MAX_HOLD cycles.
REQ-038 Neither req -> no gnt, mem_rw=1, mem_addr=0; owner_valid cleared so subsequent single m0 request with lock restarts hold_cnt at 0.
REQ-039 m0 read granted, rst=1 next cycle -> m0_rvalid stays 0; after release, first contention grants m0.

Source files
------------

// File: rtl/dmem_arb_if.sv
// Bus bundle between the two data-memory masters, the arbiter and the data memory.
// The arbiter uses the slave view; the masters and memory side use the master view.
interface dmem_arb_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              m0_req,    m1_req;
    logic              m0_we,     m1_we;
    logic              m0_lock,   m1_lock;
    logic [ADDR_W-1:0] m0_addr,   m1_addr;
    logic [DATA_W-1:0] m0_wdata,  m1_wdata;
    logic              m0_gnt,    m1_gnt;
    logic              m0_rvalid, m1_rvalid;
    logic [DATA_W-1:0] m0_rdata,  m1_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_rw;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  m0_req, m1_req, m0_we, m1_we, m0_lock, m1_lock,
        input  m0_addr, m1_addr, m0_wdata, m1_wdata, mem_rdata,
        output m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata,
        output mem_addr, mem_wdata, mem_rw
    );

    modport master (
        output m0_req, m1_req, m0_we, m1_we, m0_lock, m1_lock,
        output m0_addr, m1_addr, m0_wdata, m1_wdata, mem_rdata,
        input  m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata,
        input  mem_addr, mem_wdata, mem_rw
    );
endinterface

// File: rtl/dmem_arb.sv
// Two-master data-memory arbiter: round-robin with bounded lock ownership,
// combinational grant/mux and a single-cycle registered read return.
module dmem_arb #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_HOLD = 4
) (
    input  logic     clk,
    input  logic     rst,
    dmem_arb_if.slave bus
);
    localparam logic [3:0] HOLD_LIM = 4'(MAX_HOLD - 1);

    logic              last_q,        last_d;
    logic              owner_valid_q, owner_valid_d;
    logic [3:0]        hold_cnt_q,    hold_cnt_d;
    logic              rd_pend_q,     rd_pend_d;
    logic              rd_id_q,       rd_id_d;
    logic [DATA_W-1:0] rdata_q,       rdata_d;

    logic owner_req, owner_lock, lock_hit;
    logic gnt_any, gnt_id, gnt_we;

    always_comb begin
        owner_req  = last_q ? bus.m1_req  : bus.m0_req;
        owner_lock = last_q ? bus.m1_lock : bus.m0_lock;
        lock_hit   = owner_valid_q && owner_req && owner_lock && (hold_cnt_q < HOLD_LIM);
        gnt_any    = 1'b0;
        gnt_id     = 1'b0;
        if (!rst) begin
            if (lock_hit) begin
                gnt_any = 1'b1;
                gnt_id  = last_q;
            end else if (bus.m0_req && bus.m1_req) begin
                gnt_any = 1'b1;
                gnt_id  = ~last_q;
            end else if (bus.m0_req) begin
                gnt_any = 1'b1;
                gnt_id  = 1'b0;
            end else if (bus.m1_req) begin
                gnt_any = 1'b1;
                gnt_id  = 1'b1;
            end
        end
        gnt_we = gnt_id ? bus.m1_we : bus.m0_we;
    end

    assign bus.m0_gnt    = gnt_any & ~gnt_id;
    assign bus.m1_gnt    = gnt_any &  gnt_id;
    assign bus.mem_rw    = ~(gnt_any & gnt_we);
    assign bus.mem_addr  = gnt_any ? (gnt_id ? bus.m1_addr  : bus.m0_addr)  : '0;
    assign bus.mem_wdata = gnt_any ? (gnt_id ? bus.m1_wdata : bus.m0_wdata) : '0;

    // rvalid is masked by rst so a reset right after a read grant swallows the pulse.
    assign bus.m0_rvalid = rd_pend_q & ~rd_id_q & ~rst;
    assign bus.m1_rvalid = rd_pend_q &  rd_id_q & ~rst;
    assign bus.m0_rdata  = rdata_q;
    assign bus.m1_rdata  = rdata_q;

    always_comb begin
        last_d        = last_q;
        owner_valid_d = 1'b0;
        hold_cnt_d    = 4'd0;
        rd_pend_d     = 1'b0;
        rd_id_d       = rd_id_q;
        rdata_d       = rdata_q;
        if (gnt_any) begin
            last_d        = gnt_id;
            owner_valid_d = 1'b1;
            if (owner_valid_q && (gnt_id == last_q)) begin
                hold_cnt_d = (hold_cnt_q == 4'hF) ? 4'hF : hold_cnt_q + 4'd1;
            end
            if (!gnt_we) begin
                rd_pend_d = 1'b1;
                rd_id_d   = gnt_id;
                rdata_d   = bus.mem_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q        <= 1'b1;
            owner_valid_q <= 1'b0;
            hold_cnt_q    <= 4'd0;
            rd_pend_q     <= 1'b0;
            rd_id_q       <= 1'b0;
            rdata_q       <= '0;
        end else begin
            last_q        <= last_d;
            owner_valid_q <= owner_valid_d;
            hold_cnt_q    <= hold_cnt_d;
            rd_pend_q     <= rd_pend_d;
            rd_id_q       <= rd_id_d;
            rdata_q       <= rdata_d;
        end
    end
endmodule

// File: tb/tb_dmem_arb.sv
// Bench for dmem_arb: a transaction-level model checked every cycle plus
// directed scenarios with hand-computed literal expectations.
module tb_dmem_arb;
    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int MAX_HOLD = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dmem_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();
    dmem_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Data memory: combinational read, write on the clock edge of a write grant.
    logic [31:0] mem [0:255];
    assign bus.mem_rdata = mem[bus.mem_addr[7:0]];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'hA000_0000 | 32'(i);
        end else if (bus.mem_rw === 1'b0) begin
            mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
        end
    end

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: owner / length of its current unbroken run, and a pending read response.
    initial begin
        int          g, own, last_g, run_len, pend_id;
        bit          pend;
        bit [1:0]    rq, lk, we;
        logic [31:0] a [2];
        logic [31:0] wd [2];
        logic [31:0] exp_rdata, rd_data, ea, ewd;
        own = -1; last_g = 1; run_len = 0; pend = 0; pend_id = 0; exp_rdata = '0;
        forever begin
            @(negedge clk);
            rq = {bus.m1_req, bus.m0_req};
            lk = {bus.m1_lock, bus.m0_lock};
            we = {bus.m1_we, bus.m0_we};
            a[0] = bus.m0_addr;   a[1] = bus.m1_addr;
            wd[0] = bus.m0_wdata; wd[1] = bus.m1_wdata;
            g = -1;
            if (!rst) begin
                if (own >= 0 && rq[own] && lk[own] && run_len < MAX_HOLD) g = own;
                else if (rq == 2'b11) g = 1 - last_g;
                else if (rq[0]) g = 0;
                else if (rq[1]) g = 1;
            end
            ea  = (g >= 0) ? a[g]  : 32'h0;
            ewd = (g >= 0) ? wd[g] : 32'h0;
            chk("m0_gnt",    64'(bus.m0_gnt),    64'(g == 0));
            chk("m1_gnt",    64'(bus.m1_gnt),    64'(g == 1));
            chk("mem_rw",    64'(bus.mem_rw),    64'(!(g >= 0 && we[g])));
            chk("mem_addr",  64'(bus.mem_addr),  64'(ea));
            chk("mem_wdata", 64'(bus.mem_wdata), 64'(ewd));
            chk("m0_rvalid", 64'(bus.m0_rvalid), 64'(pend && pend_id == 0 && !rst));
            chk("m1_rvalid", 64'(bus.m1_rvalid), 64'(pend && pend_id == 1 && !rst));
            chk("m0_rdata",  64'(bus.m0_rdata),  64'(exp_rdata));
            chk("m1_rdata",  64'(bus.m1_rdata),  64'(exp_rdata));
            rd_data = (g >= 0) ? mem[a[g][7:0]] : 32'h0;
            @(posedge clk);
            if (rst) begin
                own = -1; last_g = 1; run_len = 0; pend = 0; exp_rdata = '0;
            end else if (g >= 0) begin
                run_len = (own == g) ? run_len + 1 : 1;
                if (run_len > 100) run_len = 100;
                own = g;
                last_g = g;
                pend = !we[g];
                if (!we[g]) begin
                    pend_id = g;
                    exp_rdata = rd_data;
                end
            end else begin
                own = -1; run_len = 0; pend = 0;
            end
        end
    end

    task automatic drive(input bit r0, w0, l0, input logic [31:0] a0, d0,
                         input bit r1, w1, l1, input logic [31:0] a1, d1);
        bus.m0_req = r0; bus.m0_we = w0; bus.m0_lock = l0; bus.m0_addr = a0; bus.m0_wdata = d0;
        bus.m1_req = r1; bus.m1_we = w1; bus.m1_lock = l1; bus.m1_addr = a1; bus.m1_wdata = d1;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
    endtask

    initial begin
        bit seen;
        rst = 1'b1;
        drive(1, 0, 1, 32'h10, 32'h11, 1, 1, 0, 32'h20, 32'h22);
        look();
        chk("rst_gnt",  64'({bus.m1_gnt, bus.m0_gnt}), 64'(0));
        chk("rst_rw",   64'(bus.mem_rw), 64'(1));
        chk("rst_addr", 64'(bus.mem_addr), 64'(0));
        next(); next();

        // Alternating reads after reset, m0 first.
        rst = 1'b0;
        drive(1, 0, 0, 32'h10, 32'h0, 1, 0, 0, 32'h20, 32'h0);
        for (int i = 0; i < 4; i++) begin
            look();
            chk("alt_gnt", 64'({bus.m1_gnt, bus.m0_gnt}), (i % 2) ? 64'(2) : 64'(1));
            if (i % 2 == 1) begin
                chk("alt_rv0", 64'(bus.m0_rvalid), 64'(1));
                chk("alt_rd0", 64'(bus.m0_rdata), 64'h A000_0010);
            end else if (i > 0) begin
                chk("alt_rv1", 64'(bus.m1_rvalid), 64'(1));
                chk("alt_rd1", 64'(bus.m1_rdata), 64'h A000_0020);
            end
            next();
        end
        drive(0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0);
        look();
        chk("idle_gnt",  64'({bus.m1_gnt, bus.m0_gnt}), 64'(0));
        chk("idle_rw",   64'(bus.mem_rw), 64'(1));
        chk("idle_addr", 64'(bus.mem_addr), 64'(0));
        chk("idle_rv1",  64'(bus.m1_rvalid), 64'(1));
        next();

        // m1 write then m0 read back of the same word.
        drive(0, 0, 0, 32'h0, 32'h0, 1, 1, 0, 32'h8, 32'hDEAD_BEEF);
        look();
        chk("wr_gnt1", 64'(bus.m1_gnt), 64'(1));
        chk("wr_rw",   64'(bus.mem_rw), 64'(0));
        next();
        drive(1, 0, 0, 32'h8, 32'h0, 0, 0, 0, 32'h0, 32'h0);
        look();
        chk("rd_gnt0", 64'(bus.m0_gnt), 64'(1));
        next();
        drive(0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0);
        look();
        chk("rb_rv0",   64'(bus.m0_rvalid), 64'(1));
        chk("rb_rdata", 64'(bus.m0_rdata), 64'hDEAD_BEEF);
        chk("rb_rv1",   64'(bus.m1_rvalid), 64'(0));
        next();

        // Lock hold limit: m0 locked against continuous m1 -> 4 m0 grants then m1.
        drive(0, 0, 0, 32'h0, 32'h0, 1, 0, 0, 32'h20, 32'h0);
        next();
        drive(0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0);
        next();
        drive(1, 0, 1, 32'h10, 32'h0, 1, 0, 0, 32'h20, 32'h0);
        for (int i = 0; i < 6; i++) begin
            look();
            chk("hold_seq", 64'(bus.m0_gnt), (i == 4) ? 64'(0) : 64'(1));
            next();
        end

        // Idle clears ownership: a fresh locked run gets the full hold budget again.
        drive(0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0);
        look();
        chk("clr_gnt", 64'({bus.m1_gnt, bus.m0_gnt}), 64'(0));
        next();
        drive(1, 0, 1, 32'h14, 32'h0, 0, 0, 0, 32'h0, 32'h0);
        next(); next();
        drive(1, 0, 1, 32'h14, 32'h0, 1, 0, 0, 32'h24, 32'h0);
        for (int i = 0; i < 3; i++) begin
            look();
            chk("restart_seq", 64'(bus.m0_gnt), (i == 2) ? 64'(0) : 64'(1));
            next();
        end

        // m1 alone with lock: no gaps, then m0 gets in within MAX_HOLD cycles.
        drive(0, 0, 0, 32'h0, 32'h0, 1, 0, 1, 32'h21, 32'h0);
        for (int i = 0; i < 10; i++) begin
            look();
            chk("solo_gnt1", 64'(bus.m1_gnt), 64'(1));
            next();
        end
        drive(1, 0, 0, 32'h11, 32'h0, 1, 0, 1, 32'h21, 32'h0);
        seen = 1'b0;
        for (int i = 0; i < MAX_HOLD && !seen; i++) begin
            look();
            if (bus.m0_gnt === 1'b1) seen = 1'b1;
            next();
        end
        chk("m0_within_hold", 64'(seen), 64'(1));

        // Reset right after a read grant kills the pulse; m0 wins afterwards.
        drive(1, 0, 0, 32'h12, 32'h0, 0, 0, 0, 32'h0, 32'h0);
        look();
        chk("pre_rst_gnt0", 64'(bus.m0_gnt), 64'(1));
        next();
        rst = 1'b1;
        drive(0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0);
        look();
        chk("rst_rv0", 64'(bus.m0_rvalid), 64'(0));
        next();
        rst = 1'b0;
        drive(1, 0, 0, 32'h10, 32'h0, 1, 0, 0, 32'h20, 32'h0);
        look();
        chk("post_rst_gnt0", 64'(bus.m0_gnt), 64'(1));
        next();

        // Mixed write/read contention on one word.
        drive(1, 1, 0, 32'h30, 32'h1234_5678, 1, 0, 0, 32'h30, 32'h0);
        for (int i = 0; i < 4; i++) next();
        drive(0, 1, 1, 32'h31, 32'h5555_AAAA, 1, 1, 0, 32'h32, 32'h0F0F_F0F0);
        next(); next();
        drive(0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0);
        next(); next();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
